lock_ctrl: RTL

Sequencing controller for the six-digit electronic lock. It collects keypad digits into an entry buffer and drives the combinational password comparator through its enable/result pair. It also owns the stored password register and counts failed attempts. It produces the unlock, alarm and error indications, and sits between the keypad decoder and the comparator/actuator outputs.

---
 rtl/lock_if.sv | 24 ++
 rtl/lock_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lock_if.sv
// rtl/lock_if.sv - keypad, comparator and actuator signal bundle for lock_ctrl
interface lock_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        cmp_ok;
    logic [23:0] in_code;
    logic [23:0] pw_code;
    logic        cmp_en;
    logic        unlock;
    logic        alarm;
    logic        err;
    logic [2:0]  digit_cnt;
    logic [3:0]  fail_cnt;

    modport master (
        output key_valid, key_code, cmp_ok,
        input  in_code, pw_code, cmp_en, unlock, alarm, err, digit_cnt, fail_cnt
    );

    modport slave (
        input  key_valid, key_code, cmp_ok,
        output in_code, pw_code, cmp_en, unlock, alarm, err, digit_cnt, fail_cnt
    );
endinterface

// File: rtl/lock_ctrl.sv
// rtl/lock_ctrl.sv - six-digit lock sequencer: entry buffer, compare, open/set/lockout timing
module lock_ctrl #(
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned OPEN_CYC    = 500,
    parameter int unsigned LOCKOUT_CYC = 1000,
    parameter logic [23:0] DEFAULT_PW  = 24'h123456
) (
    input  logic  clk,
    input  logic  rst,
    lock_if.slave lk
);
    localparam int unsigned TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TW = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYC - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYC - 1);
    localparam logic [3:0]    FAIL_MAX  = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_EVAL, S_OPEN, S_SET, S_LOCKOUT
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   in_code_q, in_code_d;
    logic [23:0]   pw_code_q, pw_code_d;
    logic          cmp_en_q, cmp_en_d;
    logic          unlock_q, unlock_d;
    logic          alarm_q, alarm_d;
    logic          err_q, err_d;
    logic [2:0]    digit_cnt_q, digit_cnt_d;
    logic [3:0]    fail_cnt_q, fail_cnt_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          is_digit, is_clear, is_enter, is_change;
    logic          buf_full, timer_done;
    logic [23:0]   buf_code;
    logic [2:0]    buf_cnt;

    assign is_digit   = lk.key_valid && (lk.key_code <= 4'd9);
    assign is_clear   = lk.key_valid && (lk.key_code == 4'hA);
    assign is_enter   = lk.key_valid && (lk.key_code == 4'hB);
    assign is_change  = lk.key_valid && (lk.key_code == 4'hC);
    assign buf_full   = (digit_cnt_q == 3'd6);
    assign timer_done = (timer_q == '0);

    // Entry buffer contents after applying this cycle's digit/clear key.
    always_comb begin
        buf_code = in_code_q;
        buf_cnt  = digit_cnt_q;
        if (is_clear) begin
            buf_code = '0;
            buf_cnt  = '0;
        end else if (is_digit && !buf_full) begin
            buf_code = {in_code_q[19:0], lk.key_code};
            buf_cnt  = digit_cnt_q + 3'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_code_d   = in_code_q;
        digit_cnt_d = digit_cnt_q;
        pw_code_d   = pw_code_q;
        fail_cnt_d  = fail_cnt_q;
        timer_d     = timer_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_enter) begin
                    if (buf_full) begin
                        // Buffer is held through CHECK/EVAL so the comparator sees it.
                        state_d = S_CHECK;
                    end else begin
                        err_d       = 1'b1;
                        in_code_d   = '0;
                        digit_cnt_d = '0;
                    end
                end else begin
                    in_code_d   = buf_code;
                    digit_cnt_d = buf_cnt;
                end
            end
            S_CHECK: state_d = S_EVAL;
            S_EVAL: begin
                in_code_d   = '0;
                digit_cnt_d = '0;
                if (lk.cmp_ok) begin
                    state_d    = S_OPEN;
                    fail_cnt_d = '0;
                    timer_d    = OPEN_LOAD;
                end else if (fail_cnt_q + 4'd1 == FAIL_MAX) begin
                    state_d    = S_LOCKOUT;
                    fail_cnt_d = FAIL_MAX;
                    timer_d    = LOCK_LOAD;
                end else begin
                    state_d    = S_IDLE;
                    fail_cnt_d = fail_cnt_q + 4'd1;
                    err_d      = 1'b1;
                end
            end
            S_OPEN: begin
                if (timer_done || is_enter) begin
                    state_d = S_IDLE;
                end else if (is_change) begin
                    state_d = S_SET;
                    timer_d = OPEN_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_SET: begin
                if (timer_done) begin
                    state_d     = S_IDLE;
                    in_code_d   = '0;
                    digit_cnt_d = '0;
                end else if (is_enter) begin
                    timer_d     = OPEN_LOAD;
                    in_code_d   = '0;
                    digit_cnt_d = '0;
                    if (buf_full) begin
                        pw_code_d = in_code_q;
                        state_d   = S_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (is_digit || is_clear) begin
                    timer_d     = OPEN_LOAD;
                    in_code_d   = buf_code;
                    digit_cnt_d = buf_cnt;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_LOCKOUT: begin
                if (timer_done) begin
                    state_d    = S_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmp_en_d = (state_d == S_CHECK) || (state_d == S_EVAL);
        unlock_d = (state_d == S_OPEN) || (state_d == S_SET);
        alarm_d  = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_code_q   <= '0;
            pw_code_q   <= DEFAULT_PW;
            cmp_en_q    <= 1'b0;
            unlock_q    <= 1'b0;
            alarm_q     <= 1'b0;
            err_q       <= 1'b0;
            digit_cnt_q <= '0;
            fail_cnt_q  <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_code_q   <= in_code_d;
            pw_code_q   <= pw_code_d;
            cmp_en_q    <= cmp_en_d;
            unlock_q    <= unlock_d;
            alarm_q     <= alarm_d;
            err_q       <= err_d;
            digit_cnt_q <= digit_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            timer_q     <= timer_d;
        end
    end

    assign lk.in_code   = in_code_q;
    assign lk.pw_code   = pw_code_q;
    assign lk.cmp_en    = cmp_en_q;
    assign lk.unlock    = unlock_q;
    assign lk.alarm     = alarm_q;
    assign lk.err       = err_q;
    assign lk.digit_cnt = digit_cnt_q;
    assign lk.fail_cnt  = fail_cnt_q;
endmodule
